// File: rtl/sram_bist_pkg.sv
// Shared definitions for the March C- SRAM self-test sequencer:
// FSM state codes, per-element march descriptors and the background helper.
package sram_bist_pkg;

    typedef logic [3:0] bist_state_t;

    localparam bist_state_t S_IDLE  = 4'd0;
    localparam bist_state_t S_M0    = 4'd1;
    localparam bist_state_t S_M1    = 4'd2;
    localparam bist_state_t S_M2    = 4'd3;
    localparam bist_state_t S_M3    = 4'd4;
    localparam bist_state_t S_M4    = 4'd5;
    localparam bist_state_t S_M5    = 4'd6;
    localparam bist_state_t S_DRAIN = 4'd7;
    localparam bist_state_t S_DONE  = 4'd8;

    localparam int         NUM_ELEMS = 6;
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

    // Element descriptors, bit k describes march element Mk.
    // Vectors are padded to 8 bits so any 3-bit element index stays in range;
    // the padding bits are zero (no access).
    //   M0 (w0) up, M1 (r0,w1) up, M2 (r1,w0) up,
    //   M3 (r0,w1) down, M4 (r1,w0) down, M5 (r0) up
    localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
    localparam logic [7:0] ELEM_RD_POL = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_POL = 8'b0000_1010;
    localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
    localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;

    // One bit of the data pattern: polarity 0 gives the background, 1 its inverse.
    function automatic logic bg_bit(input logic bg, input logic pol);
        return bg ^ pol;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Address generator for the March sequencer: ADDR_W-bit up/down counter
// with load-to-start-address, step enable and an end-of-element flag.
module sram_bist_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_reg;

    // Counter: load jumps to the element's start address, step moves one word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg <= '0;
        end else if (load) begin
            addr_reg <= load_down ? '1 : '0;
        end else if (step) begin
            addr_reg <= down ? (addr_reg - ADDR_ONE) : (addr_reg + ADDR_ONE);
        end
    end

    assign addr = addr_reg;
    // The final address of the sweep ends the element instead of wrapping.
    assign last = down ? (addr_reg == '0) : (addr_reg == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- self-test sequencer for the single-port SRAM macro.
// Owns the macro port while busy, runs M0..M5, compares reads one cycle
// later and reports a sticky pass/fail when done.
// Optional feature macro: SRAM_BIST_FAIL_LOG_EN (capture of first failing
// address and raw read data); when undefined fail_addr/fail_data read 0.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int                ADDR_W = 10,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              sram_men,
    output logic              sram_wen,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    bist_state_t       state_reg;
    logic              phase_reg;      // 0: read slot, 1: write slot of a r,w pair
    logic              fail_seen_reg;
    logic              cmp_valid_reg;
    logic [DATA_W-1:0] cmp_exp_reg;

    logic              is_march;
    logic              start_take;
    logic [2:0]        elem_idx;
    logic [2:0]        elem_next;
    logic              cur_down;
    logic              cur_has_rd;
    logic              cur_has_wr;
    logic              rd_pol;
    logic              wr_pol;
    logic              op_read;
    logic              op_write;
    logic              addr_done;
    logic              elem_end;
    logic              mismatch;
    logic              ag_load;
    logic              ag_load_down;
    logic              ag_step;
    logic              addr_last;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] rd_pat;
    logic [DATA_W-1:0] wr_pat;

    assign is_march   = (state_reg >= S_M0) && (state_reg <= S_M5);
    assign start_take = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // Element index is only meaningful while is_march; outside it the
    // descriptors are never consulted for an access.
    assign elem_idx   = 3'(state_reg - S_M0);
    assign elem_next  = elem_idx + 3'd1;
    assign cur_down   = ELEM_DOWN[elem_idx];
    assign cur_has_rd = ELEM_HAS_RD[elem_idx];
    assign cur_has_wr = ELEM_HAS_WR[elem_idx];
    assign rd_pol     = ELEM_RD_POL[elem_idx];
    assign wr_pol     = ELEM_WR_POL[elem_idx];

    // In a r,w element the read takes the first cycle, the write the second.
    assign op_read   = is_march && cur_has_rd && (!cur_has_wr || !phase_reg);
    assign op_write  = is_march && cur_has_wr && (!cur_has_rd || phase_reg);
    assign addr_done = op_write || (op_read && !cur_has_wr);
    assign elem_end  = addr_done && addr_last;

    assign ag_load      = start_take || (elem_end && (elem_idx != LAST_ELEM));
    assign ag_load_down = start_take ? 1'b0 : ELEM_DOWN[elem_next];
    assign ag_step      = addr_done && !addr_last;

    sram_bist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (cur_down),
        .addr      (cur_addr),
        .last      (addr_last)
    );

    // Per-bit data patterns for the current element's read and write.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_pat
            assign rd_pat[gi] = bg_bit(BG[gi], rd_pol);
            assign wr_pat[gi] = bg_bit(BG[gi], wr_pol);
        end
    endgenerate

    // Sequencer FSM: IDLE -> M0..M5 -> DRAIN -> DONE, restartable from DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            phase_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg <= S_M0;
                        phase_reg <= 1'b0;
                    end
                end
                S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                    phase_reg <= op_read && cur_has_wr;
                    if (elem_end) begin
                        state_reg <= (elem_idx == LAST_ELEM) ? S_DRAIN : (state_reg + 4'd1);
                    end
                end
                S_DRAIN: begin
                    state_reg <= S_DONE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    phase_reg <= 1'b0;
                end
            endcase
        end
    end

    // One-stage compare pipeline: remember what each read should return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_valid_reg <= 1'b0;
            cmp_exp_reg   <= '0;
        end else begin
            cmp_valid_reg <= op_read;
            if (op_read) begin
                cmp_exp_reg <= rd_pat;
            end
        end
    end

    assign mismatch = cmp_valid_reg && (sram_dout != cmp_exp_reg);

    // Sticky failure flag, cleared when a new test starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_seen_reg <= 1'b0;
        end else if (start_take) begin
            fail_seen_reg <= 1'b0;
        end else if (mismatch) begin
            fail_seen_reg <= 1'b1;
        end
    end

`ifdef SRAM_BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] cmp_addr_reg;
    logic [ADDR_W-1:0] fail_addr_reg;
    logic [DATA_W-1:0] fail_data_reg;

    // Address of the read currently in the compare stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_addr_reg <= '0;
        end else if (op_read) begin
            cmp_addr_reg <= cur_addr;
        end
    end

    // Capture only the first mismatch after start; hold it until restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_addr_reg <= '0;
            fail_data_reg <= '0;
        end else if (start_take) begin
            fail_addr_reg <= '0;
            fail_data_reg <= '0;
        end else if (mismatch && !fail_seen_reg) begin
            fail_addr_reg <= cmp_addr_reg;
            fail_data_reg <= sram_dout;
        end
    end

    assign fail_addr = fail_addr_reg;
    assign fail_data = fail_data_reg;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

    assign busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done = (state_reg == S_DONE);
    assign pass = (state_reg == S_DONE) && !fail_seen_reg;

    // Macro port is driven only during march elements; quiet otherwise.
    assign sram_men  = is_march;
    assign sram_wen  = op_write;
    assign sram_ren  = op_read;
    assign sram_addr = is_march ? cur_addr : '0;
    assign sram_din  = op_write ? wr_pat : '0;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural 1024x8 SRAM with injectable faults,
// a March C- reference built from the algorithm table, randomized faults
// and start noise, one line per failed comparison plus a summary line.
module tb_sram_march_bist;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int N      = 1 << ADDR_W;
    localparam int NOPS   = 10 * N;
    localparam logic [DATA_W-1:0] BG = 8'h00;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;
    logic              sram_men;
    logic              sram_wen;
    logic              sram_ren;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout = '0;

    int n_vectors     = 0;
    int n_miscompares = 0;

    sram_march_bist #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BG     (BG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .sram_men  (sram_men),
        .sram_wen  (sram_wen),
        .sram_ren  (sram_ren),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // Fault model: 0 none, 1 stuck-at (f_addr, f_bit, f_val),
    // 2 coupling (writing 1 on f_bit of f_addr flips f_bit of f_vic).
    int              fault_kind = 0;
    logic [ADDR_W-1:0] f_addr   = '0;
    logic [ADDR_W-1:0] f_vic    = '0;
    logic [2:0]      f_bit      = '0;
    logic            f_val      = 1'b0;

    function automatic logic [DATA_W-1:0] fault_read(input logic [ADDR_W-1:0] a,
                                                     input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] d;
        d = stored;
        if (fault_kind == 1 && a == f_addr) d[f_bit] = f_val;
        return d;
    endfunction

    // Behavioural SRAM: write on the edge, read data valid the following cycle.
    logic [DATA_W-1:0] mem [N];
    always @(posedge clk) begin
        if (sram_men && sram_wen) begin
            mem[sram_addr] <= sram_din;
            if (fault_kind == 2 && sram_addr == f_addr && sram_din[f_bit])
                mem[f_vic][f_bit] <= ~mem[f_vic][f_bit];
        end
        if (sram_men && sram_ren) sram_dout <= fault_read(sram_addr, mem[sram_addr]);
    end

    // March C- written as an algorithm table: direction, ops, op kind, polarity.
    int e_down [6]    = '{0, 0, 0, 1, 1, 0};
    int e_nops [6]    = '{1, 2, 2, 2, 2, 1};
    int e_we   [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    int e_val  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } op_t;

    op_t               exp_q [$];
    logic [DATA_W-1:0] ref_mem [N];
    bit                ref_failed;
    logic [ADDR_W-1:0] ref_fa;
    logic [DATA_W-1:0] ref_fd;

    // Expected access stream and expected first failure for the current fault.
    task automatic build_expectation();
        op_t               op;
        int                a;
        logic [DATA_W-1:0] got;
        exp_q.delete();
        ref_failed = 1'b0;
        ref_fa     = '0;
        ref_fd     = '0;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e_down[e] != 0) ? (N - 1 - i) : i;
                for (int o = 0; o < e_nops[e]; o++) begin
                    op.we = (e_we[e][o] != 0);
                    op.a  = ADDR_W'(a);
                    op.d  = (e_val[e][o] != 0) ? ~BG : BG;
                    exp_q.push_back(op);
                    if (op.we) begin
                        if (fault_kind == 2 && op.a == f_addr && op.d[f_bit])
                            ref_mem[f_vic][f_bit] = ~ref_mem[f_vic][f_bit];
                        ref_mem[op.a] = op.d;
                    end else begin
                        got = fault_read(op.a, ref_mem[op.a]);
                        if (got != op.d && !ref_failed) begin
                            ref_failed = 1'b1;
                            ref_fa     = op.a;
                            ref_fd     = got;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vectors++;
        if (got !== expv) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " done"},      32'(done),      32'd0);
        check({tag, " pass"},      32'(pass),      32'd0);
        check({tag, " fail_addr"}, 32'(fail_addr), 32'd0);
        check({tag, " fail_data"}, 32'(fail_data), 32'd0);
        check({tag, " men/wen/ren"}, 32'({sram_men, sram_wen, sram_ren}), 32'd0);
        check({tag, " sram_addr"}, 32'(sram_addr), 32'd0);
        check({tag, " sram_din"},  32'(sram_din),  32'd0);
    endtask

    task automatic randomize_fault();
        fault_kind = int'($urandom_range(0, 2));
        f_addr     = ADDR_W'($urandom_range(0, N - 1));
        f_vic      = f_addr ^ ADDR_W'($urandom_range(1, N - 1));
        f_bit      = 3'($urandom_range(0, 7));
        f_val      = 1'($urandom_range(0, 1));
    endtask

    // One test run, entered on a negedge with the DUT in IDLE or DONE.
    // hold_start keeps start high throughout; abort_at >= 0 pulses reset there.
    task automatic run_march(input bit hold_start, input int abort_at);
        op_t         op;
        logic [31:0] got;
        logic [31:0] expv;
        bit          in_sync;
        build_expectation();
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        check("start busy",      32'(busy),      32'd1);
        check("start done",      32'(done),      32'd0);
        check("start pass",      32'(pass),      32'd0);
        check("start fail_addr", 32'(fail_addr), 32'd0);
        check("start fail_data", 32'(fail_data), 32'd0);
        in_sync = 1'b1;
        for (int j = 0; j < NOPS; j++) begin
            if (j == abort_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                check_quiet("midreset");
                rst_n = 1'b1;
                return;
            end
            if (in_sync) begin
                op   = exp_q[j];
                got  = 32'({sram_men, sram_wen, sram_ren, sram_addr,
                            (op.we ? sram_din : 8'h00)});
                expv = 32'({1'b1, op.we, ~op.we, op.a, (op.we ? op.d : 8'h00)});
                check("port", got, expv);
                if (got !== expv) in_sync = 1'b0;
            end
            if (!hold_start) start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        start = hold_start;
        check("drain busy/done/men", 32'({busy, done, sram_men}), 32'b100);
        @(negedge clk);
        check("end done",  32'(done),     32'd1);
        check("end busy",  32'(busy),     32'd0);
        check("end men",   32'(sram_men), 32'd0);
        check("end pass",  32'(pass),     32'(!ref_failed));
`ifdef SRAM_BIST_FAIL_LOG_EN
        check("end fail_addr", 32'(fail_addr), 32'(ref_fa));
        check("end fail_data", 32'(fail_data), 32'(ref_fd));
`else
        check("end fail_addr", 32'(fail_addr), 32'd0);
        check("end fail_data", 32'(fail_data), 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        // Fault-free run with start noise while busy.
        fault_kind = 0;
        run_march(1'b0, -1);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        check("done held", 32'(done), 32'd1);

        // Stuck-at-1 on bit 3 of 0x155.
        fault_kind = 1; f_addr = 10'h155; f_bit = 3'd3; f_val = 1'b1;
        run_march(1'b0, -1);

        // Coupling 0x200 -> 0x201 bit 0, start held high for the whole run.
        fault_kind = 2; f_addr = 10'h200; f_vic = 10'h201; f_bit = 3'd0;
        run_march(1'b1, -1);

        // Held start restarts from DONE; this run is cut by reset at cycle 5000.
        randomize_fault();
        run_march(1'b0, 5000);
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            check("post-reset done", 32'(done), 32'd0);
        end

        // Complete fault-free run after the abandoned one.
        fault_kind = 0;
        run_march(1'b0, -1);

        // Random fault.
        randomize_fault();
        run_march(1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

March C- self-test sequencer for the 1024x8 single-port SRAM macro. On a start pulse it takes ownership of the macro's functional port (MEN/WEN/REN/ADDR/DIN, reading DOUT) and walks the full address space. It reports pass/fail and, optionally, the first failing location. It sits between the tile top-level and the SRAM instance; the top-level mux selects between user access and this block using `busy`.

## Interface
Parameters:
- `ADDR_W`, 10: SRAM address width; N = 2^ADDR_W words.
- `DATA_W`, 8: SRAM word width.
- `BG`, 8'h00: data background written as "0"; "1" is `~BG`.

Ports:
- `clk`, in, 1: clock, shared with the SRAM macro `A_CLK`.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin test; sampled only in IDLE and DONE.
- `busy`, out, 1: test in progress; the block owns the SRAM port.
- `done`, out, 1: test finished. Level; held until the next start or reset.
- `pass`, out, 1: valid while `done`=1; 1 = no mismatch.
- `fail_addr`, out, ADDR_W: address of the first mismatch. Only meaningful with `SRAM_BIST_FAIL_LOG_EN`.
- `fail_data`, out, DATA_W: read data at the first mismatch. Only meaningful with `SRAM_BIST_FAIL_LOG_EN`.
- `sram_men`, out, 1: macro enable.
- `sram_wen`, out, 1: write strobe.
- `sram_ren`, out, 1: read strobe.
- `sram_addr`, out, ADDR_W: address to the macro.
- `sram_din`, out, DATA_W: write data to the macro.
- `sram_dout`, in, DATA_W: macro read data, valid the cycle after the read edge.

## Operation
- **States:** IDLE, M0..M5, DRAIN, DONE.
- **March elements:** one SRAM operation per cycle.
  - M0 ⇕(w0), ascending.
  - M1 ⇑(r0,w1).
  - M2 ⇑(r1,w0).
  - M3 ⇓(r0,w1), from N-1 down to 0.
  - M4 ⇓(r1,w0).
  - M5 ⇑(r0).
- **Read-then-write elements:** the read and the write to the same address occupy consecutive cycles. The address advances after the write.
- **Transitions:**
  - IDLE/DONE with `start`=1 → M0 at address 0. `pass`, `fail_*` and `done` are cleared.
  - Element Mk with its last op at the final address → Mk+1 at that element's start address.
  - M5 at the last address → DRAIN.
  - DRAIN → DONE.
- **Compare pipeline:** each read registers its expected data (BG or ~BG) and its address into a one-stage pipeline. On the next cycle `sram_dout` is compared against the expected data. Any mismatch clears the sticky `pass`.
- **Port drive in M0..M5:** `sram_men`=1; exactly one of `sram_wen` / `sram_ren` is 1.
- **Port drive in IDLE, DRAIN, DONE:** `sram_men`, `sram_wen`, `sram_ren`, `sram_addr` and `sram_din` are all 0.
- **Reset values:** `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_data`=0; all `sram_*`=0; state IDLE.
- **Reset mid-test:** the test is abandoned at the first clock edge with `rst_n`=0. No completion is reported, and the SRAM contents are undefined afterwards.
- **`start` while busy:** ignored. `start` held high in DONE restarts the test every time DONE is reached.
- **Address counter:** exactly ADDR_W bits wide. The wrap from N-1 to 0 (ascending) or from 0 to N-1 (descending) is the element-end condition, never a further access.

## Timing
- `start` sampled at edge E0:
  - after E0: `busy`=1 and the first write (addr 0, data BG) is presented;
  - ops occupy edges E1..E10N;
  - after E10N+1: `done`=1, `busy`=0, `pass` final.
- For N=1024, start-to-done is 10241 cycles.
- Compare latency: 1 cycle after the read edge.
- Last compare: the M5 read of address N-1, evaluated in DRAIN.
- The mismatch capture register and the DONE transition update on the same edge, so a failure on the final read is reflected in `pass` at `done`.

## Configuration
- **Macro `SRAM_BIST_FAIL_LOG_EN` defined:** on the first mismatch after `start`, `fail_addr` and `fail_data` capture the compared address and the raw `sram_dout`. They then hold until the next start or reset.
- **Macro undefined:** `fail_addr` and `fail_data` are tied to 0 and no capture registers exist. Pass/fail behaviour is identical.

## Structure
- **Package `sram_bist_pkg`:**
  - state enum;
  - per-element descriptor constants: direction, read polarity, write polarity, has-read, has-write;
  - `NUM_ELEMS`=6;
  - background helper.
- **Sub-module `sram_bist_addr_gen`:**
  - ADDR_W up/down counter with load-to-start, step enable and a `last` flag;
  - the top-level FSM sequences it.

## Test plan
1. **Fault-free run:** fault-free SRAM model, 1-cycle `start`. Expect `busy`=1 the next cycle; `done`=1 and `pass`=1 exactly 10241 cycles after the start edge; `sram_men`=0 afterwards.
2. **Stuck-at-1:** model bit 3 of address 0x155 stuck-at-1. Expect `pass`=0. With the macro defined: `fail_addr`=0x155, `fail_data`=0x08 (first failure in M1, r0).
3. **Coupling fault:** writing 1 to 0x200 flips bit 0 of 0x201. Expect `pass`=0, `fail_addr`=0x201, `fail_data`=0x01.
4. **Access order:** cycles 1..1024 are writes of 8'h00 to addresses 0..1023 in ascending order. The first M3 access is a read of 0x3FF.
5. **Reset mid-test:** `rst_n` low for 1 cycle at cycle 5000. All outputs return to their reset values on that edge. A new `start` then runs a complete 10241-cycle test with `pass`=1.
6. **`start` handling:** `start` held high throughout a run. Pulses during busy are ignored. On reaching DONE the block restarts: `done` drops after 1 cycle and `pass`/`fail_*` clear.
